symbol_frame_decoder: RTL and testbench
=======================================

SYMBOL_FRAME_DECODER -- requirements
Module: symbol_frame_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h7E, meaning the required first byte of every frame.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sym_in, input, 2, the demodulated dibit.
REQ-005 SHALL have port sym_valid, input, 1, a one-cycle strobe marking sym_in valid.
REQ-006 SHALL have port frame_en, input, 1, a level that is high while the demodulator is inside a frame.
REQ-007 SHALL have port out_data, output, 8, a payload byte.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the byte handshake.
REQ-009 SHALL have ports frame_ok and frame_err, output, 1 each, one-cycle status pulses.
REQ-010 SHALL have port overrun, output, 1, a one-cycle pulse when a good frame is dropped.
REQ-011 SHALL have ports ok_count and err_count, output, 8 each, saturating frame counters.

Function
REQ-012 SHALL treat a frame as 32 dibits = 8 bytes: byte0 sync, bytes1-6 payload, byte7 checksum.
REQ-013 SHALL pack dibits MSB-first: byte = {d0,d1,d2,d3}, with d0 in bits 7:6.
REQ-014 SHALL use a receive FSM with states HUNT, SKIP, PAYLOAD and CSUM, and a 5-bit dibit counter.
REQ-015 SHALL change state and counters only on cycles where sym_valid is high, except for the abort in REQ-021.
REQ-016 HUNT: after the 4th dibit, byte equal to SYNC_BYTE SHALL go to PAYLOAD; any other byte SHALL go to SKIP.
REQ-017 SKIP SHALL consume dibits until 32 dibits of the frame are counted, then return to HUNT; SKIP SHALL not count as a frame error.
REQ-018 PAYLOAD SHALL store 6 bytes into the assembly buffer and keep a running XOR of them, then go to CSUM.
REQ-019 After the 4th CSUM dibit, a received byte equal to the XOR SHALL pulse frame_ok and increment ok_count; a mismatch SHALL pulse frame_err and increment err_count. Either way the FSM SHALL return to HUNT.
REQ-020 The frame_ok/frame_err pulse SHALL occur in the cycle after the final sym_valid, so latency is 1 cycle.
REQ-021 If frame_en is low while the FSM is in SKIP, PAYLOAD or CSUM, the FSM SHALL return to HUNT with the counter at 0; in PAYLOAD or CSUM it SHALL also pulse frame_err and increment err_count.
REQ-022 ok_count and err_count SHALL saturate at 8'hFF.
REQ-023 On frame_ok, if the output bank is empty, the 6 payload bytes SHALL be copied into the output bank in the same cycle as the pulse.
REQ-024 On frame_ok, if the output bank still holds undrained bytes, the new frame SHALL be dropped and overrun SHALL pulse together with frame_ok; the bank SHALL be unchanged.
REQ-025 The output side SHALL present bank bytes in order 1..6: out_valid is high while the bank is non-empty, and a byte is transferred when out_valid and out_ready are both high.
REQ-026 out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-027 The first byte SHALL appear with out_valid one cycle after the copy.
REQ-028 The bank SHALL be empty after the 6th transfer; a copy in that same cycle SHALL be accepted with no overrun.
REQ-029 Receive and drain SHALL run concurrently, so assembly of the next frame continues during drain.

Reset
REQ-030 While reset is high at a clock edge: state=HUNT, dibit counter=0, XOR=0, bank empty.
REQ-031 While reset is high at a clock edge: out_valid, out_data, frame_ok, frame_err and overrun are 0.
REQ-032 While reset is high at a clock edge: ok_count and err_count are 0.
REQ-033 Reset asserted mid-frame or mid-drain SHALL discard all partial and buffered data.

Verification
REQ-034 Good frame: dibits for 7E,01,02,03,04,05,06,07 (checksum 07), out_ready=1 -> frame_ok 1 cycle after the last strobe; out_data 01..06 on consecutive cycles; ok_count=1.
REQ-035 Bad checksum: same frame with checksum 08 -> frame_err pulse; no out_valid; err_count=1.
REQ-036 Bad sync: first byte 7F then 28 dibits, then a good frame -> the first frame is silent with no counter change; the second frame gives frame_ok.
REQ-037 Overrun: out_ready=0, then two good frames -> the first frame's bytes are held; the second gives frame_ok plus overrun; draining yields only the first frame's bytes.
REQ-038 Abort: frame_en drops after 10 dibits of a synced frame -> frame_err and err_count=1; the next full frame decodes correctly.
REQ-039 Saturation: 260 bad frames -> err_count=8'hFF.

Source files
------------

// File: rtl/symbol_frame_decoder.sv
// Dibit-to-frame decoder: packs dibits MSB-first into 8-byte frames, checks sync and XOR
// checksum, and hands good payloads to a 6-byte output bank drained with valid/ready.
module symbol_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'h7E
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    input  logic       frame_en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       overrun,
    output logic [7:0] ok_count,
    output logic [7:0] err_count
);
    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CSUM    = 2'd3;

    logic [1:0] state_r, state_s;
    logic [4:0] cnt_r, cnt_s;
    logic [5:0] shift_r;
    logic [7:0] xor_r, xor_s;
    logic [7:0] asm_r  [0:5];
    logic [7:0] bank_r [0:5];
    logic [2:0] rem_r, rd_r;
    logic       out_valid_r, frame_ok_r, frame_err_r, overrun_r;
    logic [7:0] out_data_r, ok_count_r, err_count_r;

    logic [7:0] byte_s;
    logic [2:0] asm_idx_s, rem_dec_s, rd_inc_s;
    logic       byte_done_s, abort_s, store_s, good_s, bad_s;
    logic       xfer_s, bank_free_s, copy_s, drop_s;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? (v + 8'd1) : v;
    endfunction

    // Receive FSM next-state: abort on frame_en low outranks any dibit in the same cycle
    always_comb begin
        byte_s      = {shift_r, sym_in};
        byte_done_s = sym_valid && (cnt_r[1:0] == 2'd3);
        abort_s     = !frame_en && (state_r != ST_HUNT);
        asm_idx_s   = cnt_r[4:2] - 3'd1;
        state_s     = state_r;
        cnt_s       = cnt_r;
        xor_s       = xor_r;
        store_s     = 1'b0;
        good_s      = 1'b0;
        bad_s       = 1'b0;
        if (abort_s) begin
            state_s = ST_HUNT;
            cnt_s   = 5'd0;
            xor_s   = 8'h00;
            bad_s   = (state_r == ST_PAYLOAD) || (state_r == ST_CSUM);
        end else if (sym_valid) begin
            cnt_s = cnt_r + 5'd1;
            case (state_r)
                ST_HUNT: begin
                    if (byte_done_s) begin
                        state_s = (byte_s == SYNC_BYTE) ? ST_PAYLOAD : ST_SKIP;
                        xor_s   = 8'h00;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_SKIP: begin
                    if (cnt_r == 5'd31) begin
                        state_s = ST_HUNT;
                        cnt_s   = 5'd0;
                    end else begin
                        state_s = ST_SKIP;
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_done_s) begin
                        store_s = 1'b1;
                        xor_s   = csum_step(xor_r, byte_s);
                        state_s = (cnt_r == 5'd27) ? ST_CSUM : ST_PAYLOAD;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end
                ST_CSUM: begin
                    if (cnt_r == 5'd31) begin
                        state_s = ST_HUNT;
                        cnt_s   = 5'd0;
                        xor_s   = 8'h00;
                        good_s  = (byte_s == xor_r);
                        bad_s   = (byte_s != xor_r);
                    end else begin
                        state_s = ST_CSUM;
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                    cnt_s   = 5'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output bank bookkeeping: a copy is accepted when this edge's transfer empties the bank
    always_comb begin
        xfer_s      = out_valid_r && out_ready;
        rem_dec_s   = rem_r - {2'b00, xfer_s};
        rd_inc_s    = rd_r + {2'b00, xfer_s};
        bank_free_s = (rem_dec_s == 3'd0);
        copy_s      = good_s && bank_free_s;
        drop_s      = good_s && !bank_free_s;
    end

    // State, assembly, bank and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HUNT;
            cnt_r       <= 5'd0;
            shift_r     <= 6'd0;
            xor_r       <= 8'h00;
            rem_r       <= 3'd0;
            rd_r        <= 3'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            ok_count_r  <= 8'h00;
            err_count_r <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                asm_r[i]  <= 8'h00;
                bank_r[i] <= 8'h00;
            end
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            xor_r       <= xor_s;
            shift_r     <= sym_valid ? {shift_r[3:0], sym_in} : shift_r;
            frame_ok_r  <= good_s;
            frame_err_r <= bad_s;
            overrun_r   <= drop_s;
            ok_count_r  <= sat_inc(ok_count_r, good_s);
            err_count_r <= sat_inc(err_count_r, bad_s);
            if (store_s) begin
                asm_r[asm_idx_s] <= byte_s;
            end
            if (copy_s) begin
                bank_r <= asm_r;
                rem_r  <= 3'd6;
                rd_r   <= 3'd0;
            end else begin
                rem_r  <= rem_dec_s;
                rd_r   <= rd_inc_s;
            end
            // Freshly copied bytes become visible one cycle after the copy
            out_valid_r <= (rem_dec_s != 3'd0);
            out_data_r  <= (rem_dec_s != 3'd0) ? bank_r[rd_inc_s] : 8'h00;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign frame_ok  = frame_ok_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign ok_count  = ok_count_r;
    assign err_count = err_count_r;
endmodule

// File: tb/tb_symbol_frame_decoder.sv
// Self-checking bench for symbol_frame_decoder: frame-level reference model compared
// every cycle, plus directed scenarios pinned with literal expectations.
module tb_symbol_frame_decoder;
    localparam logic [7:0] SYNC = 8'h7E;

    logic       clk = 1'b0;
    logic       reset, sym_valid, frame_en, out_ready;
    logic [1:0] sym_in;
    logic [7:0] out_data, ok_count, err_count;
    logic       out_valid, frame_ok, frame_err, overrun;

    symbol_frame_decoder #(.SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
        .frame_en(frame_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err),
        .overrun(overrun), .ok_count(ok_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;
    int ovr_seen = 0;
    logic [7:0] frm [8];
    logic [7:0] got_q [$];

    // reference model state
    int         rxq [$];
    logic [7:0] bankq [$];
    int         m_ok = 0, m_err = 0;
    logic       e_ok = 1'b0, e_err = 1'b0, e_ovr = 1'b0, e_valid = 1'b0;
    logic [7:0] e_data = 8'h00;

    function automatic logic [7:0] rx_byte(int k);
        int v;
        v = rxq[4*k]*64 + rxq[4*k+1]*16 + rxq[4*k+2]*4 + rxq[4*k+3];
        return v[7:0];
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Reference model advanced at each rising edge, compared to the DUT just after it
    always begin
        logic       r, sv, fe, rdy, good, fresh;
        int         si;
        logic [7:0] b [8];
        logic [7:0] x;
        @(posedge clk);
        r = reset; sv = sym_valid; fe = frame_en; rdy = out_ready; si = int'(sym_in);
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (overrun) ovr_seen++;
        good = 1'b0;
        fresh = 1'b0;
        if (r) begin
            rxq.delete(); bankq.delete();
            m_ok = 0; m_err = 0;
            e_ok = 1'b0; e_err = 1'b0; e_ovr = 1'b0; e_valid = 1'b0; e_data = 8'h00;
        end else begin
            e_ok = 1'b0; e_err = 1'b0; e_ovr = 1'b0;
            if (!fe && rxq.size() >= 4) begin
                if (rx_byte(0) == SYNC) begin
                    e_err = 1'b1;
                    if (m_err < 255) m_err++;
                end
                rxq.delete();
            end else if (sv) begin
                rxq.push_back(si);
                if (rxq.size() == 32) begin
                    for (int k = 0; k < 8; k++) b[k] = rx_byte(k);
                    if (b[0] == SYNC) begin
                        x = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
                        if (x == b[7]) good = 1'b1;
                        else begin
                            e_err = 1'b1;
                            if (m_err < 255) m_err++;
                        end
                    end
                    rxq.delete();
                end
            end
            if (e_valid && rdy) void'(bankq.pop_front());
            if (good) begin
                e_ok = 1'b1;
                if (m_ok < 255) m_ok++;
                if (bankq.size() == 0) begin
                    for (int k = 1; k <= 6; k++) bankq.push_back(b[k]);
                    fresh = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end
            e_valid = (bankq.size() > 0) && !fresh;
            e_data  = e_valid ? bankq[0] : 8'h00;
        end
        #1;
        vectors++;
        if (frame_ok !== e_ok || frame_err !== e_err || overrun !== e_ovr ||
            out_valid !== e_valid || (e_valid && out_data !== e_data) ||
            ok_count !== 8'(m_ok) || err_count !== 8'(m_err)) begin
            miscompares++;
            $display("FAIL cycle t=%0t ok=%b/%b err=%b/%b ovr=%b/%b valid=%b/%b data=%h/%h okc=%0d/%0d errc=%0d/%0d (got/expected)",
                     $time, frame_ok, e_ok, frame_err, e_err, overrun, e_ovr, out_valid, e_valid,
                     out_data, e_data, ok_count, m_ok, err_count, m_err);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; frame_en = 1'b0; sym_valid = 1'b0;
        idle(2);
        reset = 1'b0;
        got_q.delete();
        ovr_seen = 0;
    endtask

    task automatic send_dibits(input int n, input int gapmax);
        logic [7:0] v;
        int gap;
        for (int i = 0; i < n; i++) begin
            v = frm[i/4] >> (6 - 2*(i%4));
            @(negedge clk);
            sym_in = v[1:0];
            sym_valid = 1'b1;
            gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            repeat (gap) begin
                @(negedge clk);
                sym_valid = 1'b0;
            end
        end
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic send_frame(input int gapmax);
        frame_en = 1'b1;
        send_dibits(32, gapmax);
    endtask

    task automatic send_abort(input int n, input int gapmax);
        frame_en = 1'b1;
        send_dibits(n, gapmax);
        frame_en = 1'b0;
        @(negedge clk);
        frame_en = 1'b1;
    endtask

    task automatic load_frame(input logic [7:0] base, input logic [7:0] csum);
        frm[0] = SYNC;
        for (int k = 1; k <= 6; k++) frm[k] = base + 8'(k);
        frm[7] = csum;
    endtask

    task automatic check_drain(input string name, input logic [7:0] base);
        check({name, "_len"}, got_q.size(), 6);
        for (int k = 0; k < 6 && k < got_q.size(); k++)
            check({name, "_byte"}, int'(got_q[k]), int'(base) + k + 1);
    endtask

    initial begin
        int kind;
        reset = 1'b1; sym_valid = 1'b0; sym_in = 2'd0; frame_en = 1'b0; out_ready = 1'b1;
        idle(3);
        check("reset_ok_count", int'(ok_count), 0);
        check("reset_out_valid", int'(out_valid), 0);
        reset = 1'b0;

        // good frame
        load_frame(8'h00, 8'h07);
        send_frame(0);
        idle(10);
        check_drain("good", 8'h00);
        check("good_ok_count", int'(ok_count), 1);
        check("good_model_ok", m_ok, 1);

        // bad checksum
        do_reset();
        load_frame(8'h00, 8'h08);
        send_frame(1);
        idle(10);
        check("badcs_err_count", int'(err_count), 1);
        check("badcs_no_output", got_q.size(), 0);

        // bad sync then good frame
        do_reset();
        load_frame(8'h00, 8'h07);
        frm[0] = 8'h7F;
        send_frame(0);
        idle(3);
        check("badsync_err_count", int'(err_count), 0);
        check("badsync_ok_count", int'(ok_count), 0);
        load_frame(8'h00, 8'h07);
        send_frame(0);
        idle(10);
        check("after_sync_ok_count", int'(ok_count), 1);

        // overrun: second good frame dropped while first is held
        do_reset();
        rdy_mode = 1;
        load_frame(8'h00, 8'h07);
        send_frame(0);
        load_frame(8'h10, 8'h07);
        send_frame(0);
        idle(3);
        check("ovr_ok_count", int'(ok_count), 2);
        check("ovr_pulses", ovr_seen, 1);
        rdy_mode = 0;
        idle(12);
        check_drain("ovr_drain", 8'h00);

        // abort after 10 dibits, then a good frame
        do_reset();
        load_frame(8'h00, 8'h07);
        send_abort(10, 0);
        idle(3);
        check("abort_err_count", int'(err_count), 1);
        send_frame(0);
        idle(10);
        check("abort_then_ok", int'(ok_count), 1);
        check_drain("abort_drain", 8'h00);

        // saturation
        do_reset();
        load_frame(8'h00, 8'h08);
        repeat (260) send_frame(0);
        idle(3);
        check("sat_err_count", int'(err_count), 255);
        check("sat_model_err", m_err, 255);

        // reset mid-drain and mid-frame discards everything
        do_reset();
        rdy_mode = 1;
        load_frame(8'h20, 8'h07);
        send_frame(0);
        send_dibits(15, 0);
        do_reset();
        rdy_mode = 0;
        idle(10);
        check("midreset_no_output", got_q.size(), 0);
        load_frame(8'h30, 8'h07);
        send_frame(0);
        idle(10);
        check_drain("midreset_drain", 8'h30);

        // randomized traffic with random back-pressure
        do_reset();
        rdy_mode = 2;
        for (int f = 0; f < 80; f++) begin
            frm[0] = SYNC;
            frm[7] = 8'h00;
            for (int k = 1; k <= 6; k++) begin
                frm[k] = 8'($urandom_range(0, 255));
                frm[7] = frm[7] ^ frm[k];
            end
            kind = $urandom_range(0, 9);
            if (kind == 6 || kind == 7) frm[7] = frm[7] ^ 8'($urandom_range(1, 255));
            if (kind == 8) frm[0] = SYNC ^ 8'($urandom_range(1, 255));
            if (kind == 9) send_abort($urandom_range(5, 31), 2);
            else send_frame(($urandom_range(0, 1) == 1) ? 2 : 0);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                frame_en = ($urandom_range(0, 1) == 1);
            end
        end
        rdy_mode = 0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
